seven_segment_scan_decoder: RTL and testbench

SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

---
 rtl/seven_segment_scan_decoder.sv | 146 ++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// Recovers a 4-digit decimal number from a multiplexed 7-segment display scan (anodes + cathodes).
// Latency: digit stored 1 edge after its sample cycle; number_out/frame_valid 1 edge after the 4th digit is stored.
// Backpressure: none; the scan is observed passively and frames are emitted as pulses. Optional macro: SEG_DECODE_BLANK_EN.
module seven_segment_scan_decoder #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] number_out,
  output logic        frame_valid,
  output logic        frame_error
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam logic [15:0] CNT_SAT    = 16'(SETTLE_CYCLES);
  localparam logic [15:0] CNT_SAMPLE = 16'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  prev_anode;
  logic [15:0] settle_cnt;
  logic [3:0]  mask, mask_nxt;
  logic [3:0]  digit_q [4];

  logic        anode_ok;
  logic [1:0]  slot;
  logic        anode_change;
  logic        sample_now;
  logic        dec_ok;
  logic [3:0]  dec_digit;
  logic        store_dig;
  logic        clear_dig;
  logic        err_nxt;

  // Map the cathode pattern to a digit; anything outside the table is invalid.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    case (s)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
`ifdef SEG_DECODE_BLANK_EN
      // A dark digit is a suppressed leading zero.
      7'b1111111: r = {1'b1, 4'd0};
`endif
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Identify which digit position is driven; non-one-hot-low codes are idle.
  always_comb begin
    anode_ok = 1'b1;
    slot     = 2'd0;
    case (anode_in)
      4'b0111: slot = 2'd3;
      4'b1011: slot = 2'd2;
      4'b1101: slot = 2'd1;
      4'b1110: slot = 2'd0;
      default: anode_ok = 1'b0;
    endcase
  end

  // The change cycle still shows the previous dwell's count, so it must never sample.
  assign anode_change = (anode_in != prev_anode);
  assign sample_now   = anode_ok && !anode_change && (settle_cnt == CNT_SAMPLE);
  assign {dec_ok, dec_digit} = decode_seg(seg_in);

  // Settle counter: restart on every anode change or idle, saturate once settled.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      prev_anode <= 4'b1111;
      settle_cnt <= 16'd0;
    end else begin
      prev_anode <= anode_in;
      if (!anode_ok || anode_change)
        settle_cnt <= 16'd0;
      else if (settle_cnt != CNT_SAT)
        settle_cnt <= settle_cnt + 16'd1;
    end
  end

  // Next state and mask: EMIT clears the mask before a coincident sample lands in it.
  always_comb begin
    state_nxt = COLLECT;
    mask_nxt  = (state == EMIT) ? 4'b0000 : mask;
    store_dig = 1'b0;
    clear_dig = 1'b0;
    err_nxt   = 1'b0;
    if (sample_now) begin
      if (dec_ok) begin
        mask_nxt  = mask_nxt | (4'b0001 << slot);
        store_dig = 1'b1;
      end else begin
        mask_nxt  = 4'b0000;
        clear_dig = 1'b1;
        err_nxt   = 1'b1;
      end
    end
    if (state == COLLECT && mask_nxt == 4'b1111)
      state_nxt = EMIT;
  end

  // State, mask and digit slots; the newest sample of a slot overwrites the older one.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      mask  <= 4'b0000;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      if (clear_dig) begin
        for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
      end else if (store_dig) begin
        digit_q[slot] <= dec_digit;
      end
    end
  end

  // Output registers: number_out only changes on a complete frame.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      number_out  <= 16'd0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= (state == EMIT);
      frame_error <= err_nxt;
      if (state == EMIT)
        number_out <= 16'(digit_q[3]) * 16'd1000 + 16'(digit_q[2]) * 16'd100
                    + 16'(digit_q[1]) * 16'd10 + 16'(digit_q[0]);
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Scoreboard bench for the scan decoder: dwell-level reference model feeds an expected-event queue.
// Latency: events are expected within the dwell that produces them.
// Backpressure: none; a negedge monitor pops and compares every frame_valid/frame_error pulse.
module tb_seven_segment_scan_decoder;

  localparam int SETTLE = 4;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b0;
  logic [3:0]  anode_in     = 4'b1111;
  logic [6:0]  seg_in       = 7'b1111111;
  logic [15:0] number_out;
  logic        frame_valid;
  logic        frame_error;

  seven_segment_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .anode_in     (anode_in),
    .seg_in       (seg_in),
    .number_out   (number_out),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  typedef struct {
    bit is_err;
    int value;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         last_num = 0;
  int         m_dig[4];
  bit [3:0]   m_seen;

  logic [6:0] pat [10];
  logic [3:0] an_code [4];

  initial begin
    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    an_code = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pat_to_digit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (pat[d] == s) return d;
`ifdef SEG_DECODE_BLANK_EN
    if (s == 7'b1111111) return 0;
`endif
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (an_code[i] == a) return i;
    return -1;
  endfunction

  // Reference model works per dwell: a settled dwell contributes one digit (or kills the frame).
  task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    int sl;
    int d;
    ev_t e;
    sl = slot_of(a);
    if (sl < 0 || len <= SETTLE) return;
    d = pat_to_digit(s);
    if (d < 0) begin
      m_seen = 4'b0000;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      e.is_err = 1'b1;
      e.value  = 0;
      exp_q.push_back(e);
    end else begin
      m_dig[sl]  = d;
      m_seen[sl] = 1'b1;
      if (m_seen == 4'b1111) begin
        e.is_err = 1'b0;
        e.value  = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        exp_q.push_back(e);
        m_seen = 4'b0000;
      end
    end
  endtask

  // Hold one anode/pattern for len cycles, then one idle cycle so consecutive dwells never merge.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    model_dwell(a, s, len);
    anode_in = a;
    seg_in   = s;
    repeat (len) @(posedge clock_100Mhz);
    #1;
    anode_in = 4'b1111;
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic scan(input int n);
    dwell(4'b0111, pat[(n / 1000) % 10], 8);
    dwell(4'b1011, pat[(n / 100) % 10], 8);
    dwell(4'b1101, pat[(n / 10) % 10], 8);
    dwell(4'b1110, pat[n % 10], 8);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    m_seen = 4'b0000;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    repeat (3) @(posedge clock_100Mhz);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the expected queue; otherwise number_out holds.
  always @(negedge clock_100Mhz) begin
    ev_t e;
    if (!reset) begin
      last_num = 0;
      check("reset_number_out", int'(number_out), 0);
      check("reset_frame_valid", int'(frame_valid), 0);
      check("reset_frame_error", int'(frame_error), 0);
    end else begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_valid", int'(number_out), -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_valid", 0, int'(e.is_err));
          check("frame_number", int'(number_out), e.value);
          if (!e.is_err) last_num = e.value;
        end
      end
      if (frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_error", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_error", int'(e.is_err), 1);
        end
      end
      if (!frame_valid)
        check("number_hold", int'(number_out), last_num);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         r;
    int         len;
    int         lens [4];
    lens = '{2, 3, 8, 12};
    m_seen = 4'b0000;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;

    do_reset();
    // Idle anode codes never sample and never move outputs.
    dwell(4'b0011, pat[1], 20);
    dwell(4'b1111, pat[1], 20);
    dwell(4'b0111, pat[7], 3);
    // Basic frame.
    dwell(4'b0111, pat[3], 8);
    dwell(4'b1011, pat[4], 8);
    dwell(4'b1101, pat[0], 8);
    dwell(4'b1110, pat[9], 8);
    // Short dwell ignored, then a full scan.
    dwell(4'b0111, pat[9], 2);
    scan(1234);
    // Invalid pattern mid-frame, then recovery.
    dwell(4'b0111, pat[5], 8);
    dwell(4'b1011, 7'b1111110, 8);
    scan(7);
    // Re-sampled slot: newest digit wins.
    dwell(4'b0111, pat[5], 8);
    dwell(4'b0111, pat[6], 8);
    dwell(4'b1011, pat[1], 8);
    dwell(4'b1101, pat[2], 8);
    dwell(4'b1110, pat[3], 8);
    // Blank leading digits.
    dwell(4'b0111, 7'b1111111, 8);
    dwell(4'b1011, 7'b1111111, 8);
    dwell(4'b1101, pat[4], 8);
    dwell(4'b1110, pat[2], 8);
    scan(8080);
    // Reset mid-frame abandons the partial frame.
    dwell(4'b0111, pat[9], 8);
    dwell(4'b1011, pat[9], 8);
    dwell(4'b1101, pat[9], 8);
    do_reset();
    scan(5678);

    // Randomised dwells.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(99, 0);
      a = (r < 90) ? an_code[$urandom_range(3, 0)] : 4'($urandom_range(15, 0));
      r = $urandom_range(99, 0);
      if (r < 85)      s = pat[$urandom_range(9, 0)];
      else if (r < 95) s = 7'($urandom_range(127, 0));
      else             s = 7'b1111111;
      len = lens[$urandom_range(3, 0)];
      dwell(a, s, len);
    end

    repeat (10) @(posedge clock_100Mhz);
    #1;
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
